sprite_rom_arbiter: RTL and testbench
=====================================

SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing one sprite ROM port.
REQ-002 SHALL have parameter ADDR_W, default 10, ROM address width.
REQ-003 SHALL have parameter DATA_W, default 4, ROM word width (palette index).
REQ-004 SHALL have port vga_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port blank  input  1  high = active display region; low = blanking interval.
REQ-007 SHALL have port req  input  N_REQ  per-requester access request, level.
REQ-008 SHALL have port addr  input  N_REQ*ADDR_W  per-requester address; requester i at bits [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have port gnt  output  N_REQ  one-hot (or zero) combinational grant.
REQ-010 SHALL have port rom_address  output  ADDR_W  registered address to the synchronous sprite ROM.
REQ-011 SHALL have port rom_q  input  DATA_W  ROM data, valid one cycle after rom_address is sampled.
REQ-012 SHALL have port rd_valid  output  1  registered read-return strobe.
REQ-013 SHALL have port rd_id  output  $clog2(N_REQ)  index of the requester owning rd_data.
REQ-014 SHALL have port rd_data  output  DATA_W  registered ROM word.

Function
REQ-015 SHALL assert at most one gnt bit per cycle, and only for a requester whose req bit is high.
REQ-016 SHALL select the winner round-robin: search starts at last_grant+1 modulo N_REQ, wrapping past N_REQ-1 to 0.
REQ-017 An access is accepted at a rising edge where req[i] & gnt[i]; only acceptance updates last_grant to i.
REQ-018 On acceptance at edge k, rom_address SHALL take addr[i] at edge k and a tag {valid=1, id=i} SHALL enter a 2-stage pipeline.
REQ-019 rd_valid, rd_id, rd_data SHALL update at edge k+2, rd_data = rom_q; fixed 2-cycle latency from acceptance.
REQ-020 SHALL sustain one acceptance per cycle; back-to-back returns SHALL appear on consecutive cycles in acceptance order.
REQ-021 With no acceptance at an edge, rom_address SHALL hold its value and a zero valid bit SHALL enter the pipeline.
REQ-022 rd_valid SHALL be a one-cycle pulse per accepted access; rd_id/rd_data hold their last values when rd_valid is low.
REQ-023 A requester holding req high after acceptance is a new request and SHALL compete again under round-robin.
REQ-024 With a single requester continuously asserting, it SHALL be granted every cycle.
REQ-025 gnt SHALL depend only on req, blank and registered state; no combinational path from rom_q to any output.

Reset
REQ-026 reset_n low SHALL immediately clear rom_address, rd_valid, rd_id, rd_data and both pipeline valid bits to 0.
REQ-027 reset_n low SHALL set last_grant to N_REQ-1 so requester 0 has first priority after reset.
REQ-028 Reset mid-operation SHALL discard in-flight accesses; no rd_valid for them after release.
REQ-029 gnt SHALL be all-zero while reset_n is low.

Configuration
REQ-030 Macro SPRITE_ROM_ARB_BLANK_GATE_EN: when defined, requesters 1..N_REQ-1 are masked while blank is high; requester 0 (display pixel path) is never masked.
REQ-031 Masked requesters SHALL not receive gnt and SHALL not affect the round-robin search.
REQ-032 When SPRITE_ROM_ARB_BLANK_GATE_EN is undefined, blank SHALL be ignored and all requesters arbitrate equally.

Verification
REQ-033 Reset release, req=4'b0001, addr0=10'h005, ROM word 5 = 4'hA -> gnt=0001 same cycle; rd_valid=1, rd_id=0, rd_data=4'hA exactly 2 cycles after acceptance.
REQ-034 req=4'b1111 held 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,... ; rd_id sequence 0,1,2,3,0,... with no gaps.
REQ-035 req=4'b1010 held, last_grant=3 -> gnt 0010 then 1000 alternating; requesters 0 and 2 never granted.
REQ-036 reset_n pulsed low one cycle after two acceptances -> outputs 0 immediately; no rd_valid after release until a new acceptance.
REQ-037 Macro defined, blank=1, req=4'b0110 -> gnt=0000; blank falls to 0 -> gnt=0010 next cycle; macro undefined, same stimulus -> gnt=0010 immediately.
REQ-038 req idle for 5 cycles after access to 10'h3FF -> rom_address stays 10'h3FF, rd_valid stays 0.

Source files
------------

// File: rtl/sprite_rom_arbiter.sv
// -----------------------------------------------------------------------------
// sprite_rom_arbiter
//
// Round-robin arbiter that shares one synchronous sprite ROM port among
// N_REQ requesters. The grant is combinational. An accepted access (req & gnt
// at a rising edge) registers the requester's address onto rom_address and
// sends a {valid, id} tag down a two-stage pipeline. The ROM word comes back
// on rd_data with rd_valid/rd_id exactly two cycles after acceptance.
//
// Optional feature (macro SPRITE_ROM_ARB_BLANK_GATE_EN):
//   When defined, requesters 1..N_REQ-1 are masked while blank is high.
//   Requester 0, the display pixel path, is never masked. When the macro is
//   undefined, blank is ignored.
//
// Ports
//   vga_clk      in   sole clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   blank        in   high = active display, low = blanking interval
//   req          in   [N_REQ]          level requests
//   addr         in   [N_REQ*ADDR_W]   requester i at [i*ADDR_W +: ADDR_W]
//   gnt          out  [N_REQ]          one-hot (or zero) combinational grant
//   rom_address  out  [ADDR_W]         registered ROM address
//   rom_q        in   [DATA_W]         ROM data, one cycle after address
//   rd_valid     out                   one-cycle read-return strobe
//   rd_id        out  [$clog2(N_REQ)]  owner of rd_data
//   rd_data      out  [DATA_W]         registered ROM word
// -----------------------------------------------------------------------------
module sprite_rom_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 4
) (
  input  logic                      vga_clk,
  input  logic                      reset_n,
  input  logic                      blank,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ADDR_W-1:0]   addr,
  output logic [N_REQ-1:0]          gnt,
  output logic [ADDR_W-1:0]         rom_address,
  input  logic [DATA_W-1:0]         rom_q,
  output logic                      rd_valid,
  output logic [$clog2(N_REQ)-1:0]  rd_id,
  output logic [DATA_W-1:0]         rd_data
);

  localparam int ID_W = $clog2(N_REQ);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   gnt_id;
  logic              accept;
  logic [N_REQ-1:0]  eligible;
  logic [N_REQ-1:0]  above_last;
  logic [N_REQ-1:0]  upper_req;
  logic [N_REQ-1:0]  search_set;
  logic [ADDR_W-1:0] addr_lane [N_REQ];
  tag_t              stage1;
  tag_t              stage2;

  // Split the flat address bus into one lane per requester.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      addr_lane[i] = addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Requests that may compete this cycle.
`ifdef SPRITE_ROM_ARB_BLANK_GATE_EN
  always_comb begin
    eligible = req;
    if (blank) eligible = {{(N_REQ-1){1'b0}}, req[0]};
  end
`else
  logic unused_blank;
  assign unused_blank = blank;
  assign eligible     = req;
`endif

  // Round-robin pick: the lowest eligible requester above last_grant wins;
  // if none is above it, the search wraps and the lowest eligible wins.
  // NOTE: every signal assigned in an always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    above_last = '0;
    for (int i = 0; i < N_REQ; i++) begin
      above_last[i] = (i > int'(last_grant));
    end
    upper_req  = eligible & above_last;
    search_set = (upper_req != '0) ? upper_req : eligible;
    // x & -x isolates the lowest set bit.
    gnt        = search_set & (-search_set);
    if (!reset_n) gnt = '0;

    gnt_id = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) gnt_id = ID_W'(i);
    end
  end

  // gnt is only ever set where req is high, so any grant is an acceptance.
  assign accept = |gnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would let stage2 see the new stage1.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant  <= ID_W'(N_REQ - 1);
      rom_address <= '0;
      stage1      <= '0;
      stage2      <= '0;
      rd_valid    <= 1'b0;
      rd_id       <= '0;
      rd_data     <= '0;
    end else begin
      stage1.valid <= accept;
      stage1.id    <= gnt_id;
      if (accept) begin
        last_grant  <= gnt_id;
        rom_address <= addr_lane[gnt_id];
      end

      // The ROM samples rom_address at the edge after acceptance; its word
      // is on rom_q for the following edge, when stage2 retires.
      stage2   <= stage1;
      rd_valid <= stage2.valid;
      if (stage2.valid) begin
        rd_id   <= stage2.id;
        rd_data <= rom_q;
      end
    end
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
module tb_sprite_rom_arbiter;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 4;
  localparam int IW = 2;

  logic            vga_clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            blank   = 1'b0;
  logic [N-1:0]    req     = '1;
  logic [N*AW-1:0] addr    = '0;
  logic [N-1:0]    gnt;
  logic [AW-1:0]   rom_address;
  logic [DW-1:0]   rom_q   = '0;
  logic            rd_valid;
  logic [IW-1:0]   rd_id;
  logic [DW-1:0]   rd_data;

  sprite_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .blank       (blank),
    .req         (req),
    .addr        (addr),
    .gnt         (gnt),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .rd_valid    (rd_valid),
    .rd_id       (rd_id),
    .rd_data     (rd_data)
  );

  always #5 vga_clk = ~vga_clk;

  // Synchronous sprite ROM.
  logic [DW-1:0] rom_mem [1024];
  always @(posedge vga_clk) rom_q <= rom_mem[rom_address];

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Returns are scheduled by absolute edge number: an access accepted at
  // edge k is due at edge k+2.
  int            m_last;
  int            m_edge;
  int            ret_id   [int];
  logic [DW-1:0] ret_data [int];
  logic [AW-1:0] exp_addr;
  logic          exp_valid;
  logic [IW-1:0] exp_id;
  logic [DW-1:0] exp_data;
  logic [N-1:0]  exp_gnt;

  task automatic model_reset();
    m_last    = N - 1;
    ret_id.delete();
    ret_data.delete();
    exp_addr  = '0;
    exp_valid = 1'b0;
    exp_id    = '0;
    exp_data  = '0;
  endtask

  function automatic logic [N-1:0] model_gnt(input logic [N-1:0] r, input logic b);
    logic [N-1:0] elig;
    logic [N-1:0] g;
    bit           found;
    elig  = r;
`ifdef SPRITE_ROM_ARB_BLANK_GATE_EN
    if (b) elig = r & N'(1);
`else
    if (b) elig = r;
`endif
    g     = '0;
    found = 0;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (m_last + k) % N;
      if (!found && elig[idx]) begin
        g[idx] = 1'b1;
        found  = 1;
      end
    end
    return g;
  endfunction

  task automatic model_edge();
    m_edge++;
    for (int i = 0; i < N; i++) begin
      if (exp_gnt[i]) begin
        m_last   = i;
        exp_addr = addr[i*AW +: AW];
        ret_id[m_edge + 2]   = i;
        ret_data[m_edge + 2] = rom_mem[exp_addr];
      end
    end
    exp_valid = 1'b0;
    if (ret_id.exists(m_edge)) begin
      exp_valid = 1'b1;
      exp_id    = IW'(ret_id[m_edge]);
      exp_data  = ret_data[m_edge];
      ret_id.delete(m_edge);
      ret_data.delete(m_edge);
    end
  endtask

  task automatic check_outputs();
    check("rom_address", rom_address, exp_addr);
    check("rd_valid", rd_valid, exp_valid);
    check("rd_id", rd_id, exp_id);
    check("rd_data", rd_data, exp_data);
  endtask

  // One contiguous clock cycle: check registered outputs, drive, check gnt,
  // then advance the model on the rising edge.
  task automatic run_cycle(input logic [N-1:0] r, input logic [N*AW-1:0] a, input logic b);
    @(negedge vga_clk);
    check_outputs();
    req   = r;
    addr  = a;
    blank = b;
    #1;
    exp_gnt = model_gnt(r, b);
    check("gnt", gnt, exp_gnt);
    @(posedge vga_clk);
    model_edge();
  endtask

  task automatic do_reset();
    @(negedge vga_clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_gnt", gnt, '0);
    check("rst_rom_address", rom_address, '0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_id", rd_id, '0);
    check("rst_rd_data", rd_data, '0);
    req = '0;
    model_reset();
    @(negedge vga_clk);
    reset_n = 1'b1;
  endtask

  function automatic logic [N*AW-1:0] rand_addr();
    logic [N*AW-1:0] a;
    for (int i = 0; i < N; i++) a[i*AW +: AW] = AW'($urandom);
    return a;
  endfunction

  function automatic logic [N*AW-1:0] lane_addr(input int lane, input logic [AW-1:0] v);
    logic [N*AW-1:0] a;
    a = rand_addr();
    a[lane*AW +: AW] = v;
    return a;
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) rom_mem[i] = DW'($urandom);
    rom_mem[5] = 4'hA;
    model_reset();
    m_edge = 0;

    // Power-on reset: grant suppressed even with every request high.
    #2;
    check("por_gnt", gnt, '0);
    check("por_rd_valid", rd_valid, 1'b0);
    check("por_rom_address", rom_address, '0);
    req = '0;
    @(negedge vga_clk);
    reset_n = 1'b1;

    // Single access to word 5, returned two edges later.
    run_cycle(4'b0001, lane_addr(0, 10'h005), 1'b0);
    run_cycle(4'b0000, rand_addr(), 1'b0);
    run_cycle(4'b0000, rand_addr(), 1'b0);
    #1;
    check("w5_rd_valid", rd_valid, 1'b1);
    check("w5_rd_id", rd_id, 2'd0);
    check("w5_rd_data", rd_data, 4'hA);

    // All four requesting: strict rotation with no return gaps.
    do_reset();
    for (int c = 0; c < 10; c++) run_cycle(4'b1111, rand_addr(), 1'b0);

    // Requesters 1 and 3 alternate.
    do_reset();
    for (int c = 0; c < 8; c++) run_cycle(4'b1010, rand_addr(), 1'b0);

    // Reset with two accesses in flight discards both.
    do_reset();
    run_cycle(4'b0001, rand_addr(), 1'b0);
    run_cycle(4'b0010, rand_addr(), 1'b0);
    do_reset();
    for (int c = 0; c < 4; c++) run_cycle(4'b0000, rand_addr(), 1'b0);

    // Blank gating (expectation follows the build configuration).
    run_cycle(4'b0110, rand_addr(), 1'b1);
    run_cycle(4'b0110, rand_addr(), 1'b0);
    run_cycle(4'b0000, rand_addr(), 1'b0);

    // Last-address hold while idle.
    run_cycle(4'b0100, lane_addr(2, 10'h3FF), 1'b0);
    for (int c = 0; c < 5; c++) run_cycle(4'b0000, rand_addr(), 1'b0);
    #1;
    check("hold_rom_address", rom_address, 10'h3FF);
    check("hold_rd_valid", rd_valid, 1'b0);

    // Single continuous requester is granted every cycle.
    for (int c = 0; c < 6; c++) run_cycle(4'b0100, rand_addr(), 1'b0);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 2000; c++) begin
      logic [N-1:0] r;
      r = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      if ($urandom_range(0, 199) == 0) do_reset();
      run_cycle(r, rand_addr(), 1'($urandom_range(0, 1)));
    end
    run_cycle(4'b0000, rand_addr(), 1'b0);
    run_cycle(4'b0000, rand_addr(), 1'b0);
    run_cycle(4'b0000, rand_addr(), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
